// File: rtl/odbiornik_uart_pkg.sv
// uart_pakiet: shared UART word length, default clocks per bit and receiver FSM states
package uart_pakiet;
  localparam int DLUGOSC_SLOWA = 8;
  localparam int CLK_NA_BIT_DOMYSLNY = 16;
  typedef enum logic [2:0] {BEZCZYNNY, START, DANE, STOP, CZEKAJ} stan_e;
endpackage

// File: rtl/odbiornik_uart_if.sv
// odbiornik_uart_if: receiver bus (master drives wejscie_odb in, slowo_odb/odebrano/blad_ramki/odbior out; slave is the consumer)
interface odbiornik_uart_if;
  import uart_pakiet::*;
  logic wejscie_odb;
  logic [DLUGOSC_SLOWA-1:0] slowo_odb;
  logic odebrano;
  logic blad_ramki;
  logic odbior;
  modport master (input wejscie_odb, output slowo_odb, odebrano, blad_ramki, odbior);
  modport slave (output wejscie_odb, input slowo_odb, odebrano, blad_ramki, odbior);
endinterface

// File: rtl/odbiornik_uart_synchronizator_wej.sv
// synchronizator_wej: 2-flop synchronizer, sync set-to-1 on RST (CLK, RST, d_i async in, q_o synced out)
module synchronizator_wej (
  input  logic CLK,
  input  logic RST,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge CLK) sync_q <= RST ? 2'b11 : {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/odbiornik_uart.sv
// odbiornik_uart: 8N1 UART receiver FSM (CLK, RST, bus: wejscie_odb in, slowo_odb/odebrano/blad_ramki/odbior out)
module odbiornik_uart
  import uart_pakiet::*;
#(
  parameter int CLK_NA_BIT = CLK_NA_BIT_DOMYSLNY
) (
  input logic CLK,
  input logic RST,
  odbiornik_uart_if.master bus
);
  localparam int H = CLK_NA_BIT / 2;
  localparam int LW = $clog2(CLK_NA_BIT);
  stan_e stan_q;
  logic [LW-1:0] lcz_q;
  logic [2:0] bit_q;
  logic [DLUGOSC_SLOWA-1:0] rej_q, slowo_q;
  logic odebrano_q, blad_q, odbior_q;
  logic rx_s, pol_startu, pol_bitu;
  synchronizator_wej u_sync (.CLK(CLK), .RST(RST), .d_i(bus.wejscie_odb), .q_o(rx_s));
  assign pol_startu = lcz_q == LW'(H - 1);
  assign pol_bitu = lcz_q == LW'(CLK_NA_BIT - 1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      stan_q <= BEZCZYNNY;
      lcz_q <= '0;
      bit_q <= '0;
      rej_q <= '0;
      slowo_q <= '0;
      odebrano_q <= 1'b0;
      blad_q <= 1'b0;
      odbior_q <= 1'b0;
    end else begin
      odebrano_q <= 1'b0;
      blad_q <= 1'b0;
      lcz_q <= lcz_q + 1'b1;
      case (stan_q)
        BEZCZYNNY: if (!rx_s) begin
          stan_q <= START;
          lcz_q <= '0;
          odbior_q <= 1'b1;
        end
        START: if (pol_startu) begin
          stan_q <= rx_s ? BEZCZYNNY : DANE;
          odbior_q <= !rx_s;
          lcz_q <= '0;
          bit_q <= '0;
        end
        DANE: if (pol_bitu) begin
          lcz_q <= '0;
          rej_q <= {rx_s, rej_q[DLUGOSC_SLOWA-1:1]};
          bit_q <= bit_q + 1'b1;
          if (bit_q == 3'(DLUGOSC_SLOWA - 1)) stan_q <= STOP;
        end
        STOP: if (pol_bitu) begin
          lcz_q <= '0;
          stan_q <= rx_s ? BEZCZYNNY : CZEKAJ;
          odbior_q <= !rx_s;
          odebrano_q <= rx_s;
          blad_q <= !rx_s;
          if (rx_s) slowo_q <= rej_q;
        end
        CZEKAJ: if (rx_s) begin
          stan_q <= BEZCZYNNY;
          odbior_q <= 1'b0;
        end
        default: stan_q <= BEZCZYNNY;
      endcase
    end
  end
  assign bus.slowo_odb = slowo_q;
  assign bus.odebrano = odebrano_q;
  assign bus.blad_ramki = blad_q;
  assign bus.odbior = odbior_q;
endmodule

// File: tb/tb_odbiornik_uart.sv
// tb_odbiornik_uart: directed and random frames checked against a frame-level timing/value model
module tb_odbiornik_uart;
  localparam int N = 4;
  localparam int H = N / 2;
  localparam int LAT = 3 + H + 9 * N;
  typedef struct {int c; logic [7:0] w; bit e;} zd_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int total = 0, bad = 0, both = 0;
  logic [7:0] last = 8'h00;
  zd_t got_q[$], exp_q[$];
  odbiornik_uart_if bus ();
  odbiornik_uart #(.CLK_NA_BIT(N)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.odebrano && bus.blad_ramki) both++;
    if (bus.odebrano) got_q.push_back(zd_t'{cyc, bus.slowo_odb, 1'b0});
    if (bus.blad_ramki) got_q.push_back(zd_t'{cyc, bus.slowo_odb, 1'b1});
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic to_neg(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input bit stopb, input int nb);
    logic [9:0] seq;
    seq = {stopb, b, 1'b0};
    if (nb == 10) begin
      exp_q.push_back(zd_t'{cyc + LAT, stopb ? b : last, !stopb});
      if (stopb) last = b;
    end
    for (int i = 0; i < nb; i++) begin
      bus.wejscie_odb = seq[i];
      repeat (N) @(posedge clk);
      #1;
    end
  endtask
  task automatic drain(input string tag);
    zd_t g, e;
    for (int k = 0; k < 200 && got_q.size() < exp_q.size(); k++) @(negedge clk);
    repeat (2 * N) @(posedge clk);
    #1;
    chk({tag, " count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, " cycle"}, g.c, e.c);
      chk({tag, " word"}, {24'd0, g.w}, {24'd0, e.w});
      chk({tag, " err"}, {31'd0, g.e}, {31'd0, e.e});
    end
    got_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int l, g;
    bus.wejscie_odb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst slowo", {24'd0, bus.slowo_odb}, 32'h0);
    chk("rst odebrano", {31'd0, bus.odebrano}, 32'h0);
    chk("rst blad", {31'd0, bus.blad_ramki}, 32'h0);
    chk("rst odbior", {31'd0, bus.odbior}, 32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(8'h99, 1'b1, 10);
    drain("f99");
    chk("f99 slowo", {24'd0, bus.slowo_odb}, 32'h99);
    send(8'h55, 1'b1, 10);
    send(8'hA0, 1'b1, 10);
    drain("b2b");
    send(8'h3C, 1'b0, 10);
    repeat (20) @(posedge clk);
    #1;
    chk("czekaj odbior", {31'd0, bus.odbior}, 32'h1);
    l = cyc;
    bus.wejscie_odb = 1'b1;
    to_neg(l + 2);
    chk("czekaj hold", {31'd0, bus.odbior}, 32'h1);
    to_neg(l + 3);
    chk("czekaj exit", {31'd0, bus.odbior}, 32'h0);
    drain("ferr");
    chk("ferr slowo", {24'd0, bus.slowo_odb}, 32'hA0);
    @(posedge clk);
    #1;
    g = cyc;
    bus.wejscie_odb = 1'b0;
    @(posedge clk);
    #1;
    bus.wejscie_odb = 1'b1;
    to_neg(g + 3);
    chk("glitch odbior up", {31'd0, bus.odbior}, 32'h1);
    to_neg(g + 5);
    chk("glitch odbior down", {31'd0, bus.odbior}, 32'h0);
    drain("glitch");
    @(posedge clk);
    #1;
    send(8'h81, 1'b1, 10);
    drain("f81");
    send(8'hFF, 1'b1, 5);
    bus.wejscie_odb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    last = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst slowo", {24'd0, bus.slowo_odb}, 32'h0);
    chk("midrst odbior", {31'd0, bus.odbior}, 32'h0);
    drain("midrst");
    send(8'h12, 1'b1, 10);
    drain("f12");
    for (int i = 0; i < 12; i++) begin
      send(8'($urandom_range(0, 255)), 1'b1, 10);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain("rand");
    chk("never both", both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/odbiornik_uart.md
# odbiornik_uart

UART receiver for 8N1 frames, the receive-side counterpart of the team's UART transmitter. It samples the asynchronous serial line with the system clock at a fixed number of clocks per bit and reassembles one 8-bit word per frame, LSB first. It presents each word with a one-cycle strobe and flags framing errors. It sits between the external RX pin and any consumer logic that reads received bytes.

## Interface
- `CLK_NA_BIT`, default 16: system clocks per serial bit. Must be even and ≥ 4.
- `CLK` in, 1 bit: system clock; all logic is on the rising edge.
- `RST` in, 1 bit: reset, synchronous, active-high.
- `wejscie_odb` in, 1 bit: asynchronous serial line; idles at 1.
- `slowo_odb` out, 8 bits: last correctly received word; held until the next good frame.
- `odebrano` out, 1 bit: one-cycle strobe; `slowo_odb` is valid and new in the cycle this is high.
- `blad_ramki` out, 1 bit: one-cycle strobe when the stop bit samples as 0.
- `odbior` out, 1 bit: high whenever the FSM is not in BEZCZYNNY.

## Operation
- `wejscie_odb` passes through a 2-flop synchronizer; both flops reset to 1. `rx_s` denotes the synchronized line.
- FSM states: BEZCZYNNY, START, DANE, STOP, CZEKAJ.
  - BEZCZYNNY: if `rx_s == 0`, go to START and clear the clock counter.
  - START: at count H−1 (H = CLK_NA_BIT/2), sample `rx_s`. If 1 (false start), go to BEZCZYNNY. If 0, go to DANE; clear the clock counter and the bit counter.
  - DANE: every CLK_NA_BIT clocks, sample `rx_s` and shift it into the shift register from the MSB side (shift right). After bit 7, go to STOP.
  - STOP: after CLK_NA_BIT clocks, sample `rx_s`.
    - If 1: load `slowo_odb`, pulse `odebrano`, go to BEZCZYNNY.
    - If 0: pulse `blad_ramki`, leave `slowo_odb` unchanged, go to CZEKAJ.
  - CZEKAJ (break/line-low guard): stay until `rx_s == 1`, then go to BEZCZYNNY. No new start is detected while in this state.
- Clock counter width is clog2(CLK_NA_BIT); it wraps to 0 on every sample point. The bit counter is 3 bits; the transition to STOP happens when it is 7 at a sample.
- `odebrano` and `blad_ramki` are never high in the same cycle.

## Timing
- Reset values: `slowo_odb` = 8'h00, `odebrano` = 0, `blad_ramki` = 0, `odbior` = 0, FSM = BEZCZYNNY, shift register = 0.
- `rx_s` lags `wejscie_odb` by 2 clocks.
- Let t0 be the edge at which the FSM enters START.
  - Start-bit sample: edge t0+H.
  - Data bit k (k = 0..7): edge t0+H+(k+1)·CLK_NA_BIT.
  - Stop sample: edge t0+H+9·CLK_NA_BIT.
  - `odebrano` or `blad_ramki` is high for exactly the one cycle after the stop-sample edge.
- Back-to-back frames: the FSM is in BEZCZYNNY in the cycle the strobe is high. A start bit immediately following the stop bit (with a half-bit stop margin) is therefore caught with no lost frame.
- `odbior` rises the cycle after t0. It falls in the same cycle the strobe rises, or when CZEKAJ exits.
- RST mid-frame, on any edge: the frame is abandoned, no strobe is issued, all outputs take their reset values, and the synchronizer is set to 1.
- A low glitch on `rx_s` shorter than H clocks causes a return to BEZCZYNNY with no strobe.

## Structure
- Package `uart_pakiet` holds:
  - the FSM state typedef;
  - `DLUGOSC_SLOWA` = 8;
  - the default `CLK_NA_BIT`, shared with the transmitter.
- Sub-module `synchronizator_wej`: 2-flop synchronizer with a synchronous set-to-1 on `RST`. Reusable for other asynchronous inputs.
- Everything else lives in one FSM module: counters, shift register and output registers.

## Test plan
All scenarios use CLK_NA_BIT = 4.
- Reset, then drive frame 0x99 (line sequence 0,1,0,0,1,1,0,0,1,1) → `odebrano` high for 1 cycle at t0+2+36, `slowo_odb` = 8'h99, `blad_ramki` = 0.
- Frames 0x55 then 0xA0 back-to-back with no idle gap → two `odebrano` pulses 40 clocks apart; `slowo_odb` = 8'h55, then 8'hA0.
- Frame 0x3C with stop bit 0, line held low for 20 further clocks, then 1 → `blad_ramki` pulses once, `slowo_odb` keeps its previous value, and `odbior` stays high until 2 clocks after the line returns to 1.
- 1-clock low glitch on an idle line → `odbior` high briefly, then no strobe; a following 0x81 frame is received correctly.
- `RST` asserted at data bit 4 of frame 0xFF, then released → no strobe, `slowo_odb` = 8'h00, `odbior` = 0; the next frame 0x12 is received correctly.
